add_share_arb: RTL

ADD_SHARE_ARB -- requirements
Module: add_share_arb

---
 rtl/add_share_arb.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/add_share_arb.sv
// I/Q integrate-and-dump with one adder shared between channels by a
// round-robin arbiter; sums are handed out through a valid/ready dump port.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   en                 enables accumulation (low = no grants)
//   i_valid/i_data     I sample offer, i_ready = I grant (combinational)
//   q_valid/q_data     Q sample offer, q_ready = Q grant (combinational)
//   dump_i/dump_q      final period sums (registered)
//   dump_valid         dump handshake valid (registered)
//   dump_ready         consumer accepts the dump
module add_share_arb #(
    parameter int SIZE     = 8,
    parameter int DUMP_LEN = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   i_valid,
    input  logic signed [SIZE-1:0] i_data,
    output logic                   i_ready,
    input  logic                   q_valid,
    input  logic signed [SIZE-1:0] q_data,
    output logic                   q_ready,
    output logic signed [SIZE-1:0] dump_i,
    output logic signed [SIZE-1:0] dump_q,
    output logic                   dump_valid,
    input  logic                   dump_ready
);

    localparam int CW = $clog2(DUMP_LEN + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DUMP_LEN);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DUMP = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic signed [SIZE-1:0] acc_i_q, acc_i_d;
    logic signed [SIZE-1:0] acc_q_q, acc_q_d;
    logic [CW-1:0]          cnt_i_q, cnt_i_d;
    logic [CW-1:0]          cnt_q_q, cnt_q_d;
    // 1 = Q was granted last, so I wins the next tie
    logic                   last_q, last_d;
    logic signed [SIZE-1:0] dump_i_q, dump_i_d;
    logic signed [SIZE-1:0] dump_q_q, dump_q_d;
    logic                   dump_valid_q, dump_valid_d;

    logic elig_i, elig_q;
    logic gnt_i, gnt_q;

    logic signed [SIZE-1:0] add_a, add_b, sum;

    // Arbitration
    assign elig_i = i_valid && (cnt_i_q < CNT_MAX) && (state_q == ACC) && en;
    assign elig_q = q_valid && (cnt_q_q < CNT_MAX) && (state_q == ACC) && en;

    // On a tie the channel not served last goes first
    assign gnt_i = elig_i && (!elig_q || last_q);
    assign gnt_q = elig_q && (!elig_i || !last_q);

    assign i_ready = gnt_i;
    assign q_ready = gnt_q;

    // The one shared adder: operands steered by the grant, carry dropped
    assign add_a = gnt_q ? acc_q_q : acc_i_q;
    assign add_b = gnt_q ? q_data  : i_data;
    assign sum   = add_a + add_b;

    always_comb begin
        state_d      = state_q;
        acc_i_d      = acc_i_q;
        acc_q_d      = acc_q_q;
        cnt_i_d      = cnt_i_q;
        cnt_q_d      = cnt_q_q;
        last_d       = last_q;
        dump_i_d     = dump_i_q;
        dump_q_d     = dump_q_q;
        dump_valid_d = dump_valid_q;

        unique case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = ACC;
                end
            end
            ACC: begin
                if (!en) begin
                    // partial sums and counters are kept for resumption
                    state_d = IDLE;
                end else begin
                    if (gnt_i) begin
                        acc_i_d = sum;
                        cnt_i_d = cnt_i_q + CNT_ONE;
                        last_d  = 1'b0;
                    end
                    if (gnt_q) begin
                        acc_q_d = sum;
                        cnt_q_d = cnt_q_q + CNT_ONE;
                        last_d  = 1'b1;
                    end
                    // dump captures the sums including this edge's sample
                    if (cnt_i_d == CNT_MAX && cnt_q_d == CNT_MAX) begin
                        state_d      = DUMP;
                        dump_valid_d = 1'b1;
                        dump_i_d     = acc_i_d;
                        dump_q_d     = acc_q_d;
                    end
                end
            end
            DUMP: begin
                if (dump_valid_q && dump_ready) begin
                    dump_valid_d = 1'b0;
                    acc_i_d      = '0;
                    acc_q_d      = '0;
                    cnt_i_d      = '0;
                    cnt_q_d      = '0;
                    state_d      = en ? ACC : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            acc_i_q      <= '0;
            acc_q_q      <= '0;
            cnt_i_q      <= '0;
            cnt_q_q      <= '0;
            last_q       <= 1'b1;
            dump_i_q     <= '0;
            dump_q_q     <= '0;
            dump_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_i_q      <= acc_i_d;
            acc_q_q      <= acc_q_d;
            cnt_i_q      <= cnt_i_d;
            cnt_q_q      <= cnt_q_d;
            last_q       <= last_d;
            dump_i_q     <= dump_i_d;
            dump_q_q     <= dump_q_d;
            dump_valid_q <= dump_valid_d;
        end
    end

    assign dump_i     = dump_i_q;
    assign dump_q     = dump_q_q;
    assign dump_valid = dump_valid_q;

endmodule
